div64_byte_host: RTL
====================

Name: div64_byte_host

Overview:
- Host-side end of the div64 byte-serial link.
- Takes two 64-bit operands in parallel and streams them as 16 bytes onto the divider's 8-bit `data_in`.
- Then collects the 16 result bytes (quotient, then remainder) qualified by the divider's `done`, and presents them as parallel 64-bit words.
- Sits between a parallel requester (CPU/test harness) and `div64_top`.

Parameters:
- OPERAND_W, 64, operand/result width in bits; must be a multiple of BYTE_W.
- BYTE_W, 8, link byte width.
- TIMEOUT_CYC, 1023, maximum idle cycles waiting for result bytes before abort.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request strobe; accepted only when busy=0
- a_in  in  OPERAND_W  dividend, sampled on accepted start
- b_in  in  OPERAND_W  divisor, sampled on accepted start
- busy  out  1  high from accept until res_valid cycle inclusive
- tx_data  out  BYTE_W  byte to divider data_in
- tx_valid  out  1  tx_data holds a valid operand byte
- rx_data  in  BYTE_W  byte from divider data_out
- rx_valid  in  1  divider done; qualifies rx_data
- div_err  in  1  divider err
- quotient  out  OPERAND_W  captured quotient, held until next res_valid
- remainder  out  OPERAND_W  captured remainder, held until next res_valid
- res_valid  out  1  one-cycle pulse: quotient/remainder/err/timeout valid
- err  out  1  divide error seen during transaction; held with results
- timeout  out  1  transaction aborted by timeout; held with results

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0.
- Byte count per transaction: NB = 2*OPERAND_W/BYTE_W (16 at defaults).
- FSM states: IDLE, SEND, WAIT, RECV, REPORT.
- IDLE:
  - On start=1, latch {a_in,b_in} into a 2*OPERAND_W shift register, clear err/timeout, go to SEND.
  - rx_valid is ignored.
- SEND:
  - tx_valid=1; tx_data = top byte of the shift register.
  - Shift left one byte per cycle.
  - Order is a MSB byte first through a LSB byte, then b MSB through b LSB.
  - Exactly NB consecutive cycles, no gaps.
  - After byte NB-1, go to WAIT with tx_valid=0 and tx_data=0.
- Send timing: start accepted at edge 0; bytes appear during cycles 1..NB.
- WAIT:
  - Timeout counter increments each cycle.
  - On rx_valid=1, capture the byte and go to RECV; that byte counts as byte 0.
  - If the counter reaches TIMEOUT_CYC with no rx_valid, set timeout=1 and go to REPORT.
- RECV:
  - Capture rx_data on every rx_valid=1 cycle into a 2*OPERAND_W result shift register, shifting left (MSB-first).
  - Gaps (rx_valid=0) are allowed. The timeout counter resets on each captured byte and runs during gaps; on expiry, go to REPORT with timeout=1 and partial data.
  - After byte NB-1 is captured, go to REPORT.
  - Mapping: quotient = first OPERAND_W bits received; remainder = last OPERAND_W bits.
- err capture: err is sticky; it ORs in div_err on every cycle in WAIT and RECV.
- REPORT:
  - Update quotient/remainder from the result register.
  - res_valid=1 for exactly one cycle; busy=1 during this cycle.
  - Go to IDLE.
  - err/timeout remain valid until the next accepted start.
- start while busy=1 is ignored, with no queueing.
- A start on the same cycle as REPORT is ignored; start is accepted the cycle after.
- rx_valid during SEND or IDLE is ignored (stray bytes are discarded).
- rst asserted mid-transaction: next cycle is IDLE, all outputs 0, partial data discarded.
- Widths: byte index counter is ceil(log2(NB)) bits; the timeout counter is wide enough for TIMEOUT_CYC with no wrap (it saturates at expiry).

Decomposition:
- Shared package `div64_pkg`:
  - state enum (IDLE, SEND, WAIT, RECV, REPORT)
  - BYTE_W, OPERAND_W and NB constants, shared with the receiving side of the link.
- Sub-module `byte_shift_reg` (parallel load, shift-out-MSB byte, shift-in-LSB byte).
  - Instanced twice: once as the tx serializer, once as the rx deserializer.

Test Plan:
1. Serialization:
   - Stimulus: a=0x0123456789ABCDEF, b=0xFEDCBA9876543210, start.
   - Response: tx_valid high cycles 1..16; tx_data = 01,23,...,EF,FE,DC,...,10 in order.
2. Normal divide, looped through a div64_top model:
   - Stimulus: a=100, b=7.
   - Response: res_valid pulse; quotient=14, remainder=2, err=0, timeout=0.
3. Divide by zero:
   - Stimulus: a=5, b=0; model asserts div_err.
   - Response: err=1 at res_valid; err held until next start.
4. Gapped receive:
   - Stimulus: result bytes with rx_valid 1,0,0,1,... (16 bytes over 40 cycles).
   - Response: correct quotient/remainder; no timeout.
5. Timeout:
   - Stimulus: no rx_valid after send, TIMEOUT_CYC=20.
   - Response: res_valid at WAIT entry+20, timeout=1; busy drops the following cycle.
6. Reset and start robustness:
   - Stimulus (a): rst pulsed at send byte 7.
   - Response (a): tx_valid=0 and busy=0 next cycle.
   - Stimulus (b): start pulsed during RECV.
   - Response (b): ignored, and the transaction completes unchanged.

Source files
------------

// File: rtl/div64_pkg.sv
// Shared definitions for both ends of the div64 byte-serial link.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package div64_pkg;

  localparam int BYTE_W    = 8;
  localparam int OPERAND_W = 64;
  // Bytes per transaction in each direction: two operands out, quotient+remainder back.
  localparam int NB        = 2 * OPERAND_W / BYTE_W;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT,
    RECV,
    REPORT
  } state_e;

endpackage

// File: rtl/div64_byte_host_shift.sv
// Byte-granular shift register: parallel load, shifts left one byte per enable,
// new byte enters at the LSB end. Latency: 1 cycle load/shift. Backpressure: none.
// Ports: clk/rst, load_i+load_dat_i (load wins over shift), shift_i+byte_i, q_o (full contents).
module byte_shift_reg #(
  parameter int W      = 2 * div64_pkg::OPERAND_W,
  parameter int BYTE_W = div64_pkg::BYTE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [W-1:0]      load_dat_i,
  input  logic              shift_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [W-1:0]      q_o
);

  logic [W-1:0] q_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else if (load_i) begin
      q_q <= load_dat_i;
    end else if (shift_i) begin
      q_q <= {q_q[W-BYTE_W-1:0], byte_i};
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/div64_byte_host.sv
// Host end of the div64 link: serializes {a,b} MSB-first, collects quotient/remainder bytes.
// Latency: bytes out on cycles 1..NB after accepted start; res_valid 1 cycle after last rx byte.
// Backpressure: start ignored while busy; rx gaps tolerated up to TIMEOUT_CYC idle cycles.
// Ports: clk/rst; start,a_in,b_in,busy (request side); tx_data/tx_valid, rx_data/rx_valid, div_err
// (divider side); quotient, remainder, res_valid, err, timeout (result side).
module div64_byte_host #(
  parameter int OPERAND_W   = div64_pkg::OPERAND_W,
  parameter int BYTE_W      = div64_pkg::BYTE_W,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [OPERAND_W-1:0] a_in,
  input  logic [OPERAND_W-1:0] b_in,
  output logic                 busy,
  output logic [BYTE_W-1:0]    tx_data,
  output logic                 tx_valid,
  input  logic [BYTE_W-1:0]    rx_data,
  input  logic                 rx_valid,
  input  logic                 div_err,
  output logic [OPERAND_W-1:0] quotient,
  output logic [OPERAND_W-1:0] remainder,
  output logic                 res_valid,
  output logic                 err,
  output logic                 timeout
);

  import div64_pkg::*;

  localparam int W2     = 2 * OPERAND_W;
  localparam int NUM_B  = W2 / BYTE_W;
  localparam int BCNT_W = (NUM_B > 1) ? $clog2(NUM_B) : 1;
  localparam int TCNT_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [BCNT_W-1:0] LAST_B  = BCNT_W'(NUM_B - 1);
  localparam logic [TCNT_W-1:0] TMO_LIM = TCNT_W'(TIMEOUT_CYC);

  state_e                state_q, state_d;
  logic [BCNT_W-1:0]     bcnt_q, bcnt_d;
  logic [TCNT_W-1:0]     tcnt_q, tcnt_d;
  logic [TCNT_W-1:0]     tcnt_inc;
  logic                  err_q, err_d;
  logic                  tmo_q, tmo_d;
  logic [OPERAND_W-1:0]  quo_q, quo_d;
  logic [OPERAND_W-1:0]  rem_q, rem_d;

  logic                  tx_load;
  logic                  tx_shift;
  logic                  rx_cap;
  logic [W2-1:0]         tx_q;
  logic [W2-1:0]         rx_q;
  logic [W2-1:0]         rx_nxt;

  // Operand serializer: top byte is always the next byte on the wire.
  byte_shift_reg #(.W(W2), .BYTE_W(BYTE_W)) u_tx_ser (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tx_load),
    .load_dat_i ({a_in, b_in}),
    .shift_i    (tx_shift),
    .byte_i     ('0),
    .q_o        (tx_q)
  );

  // Result deserializer: cleared on accept so a timed-out transaction reports
  // only the bytes that actually arrived.
  byte_shift_reg #(.W(W2), .BYTE_W(BYTE_W)) u_rx_des (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tx_load),
    .load_dat_i ('0),
    .shift_i    (rx_cap),
    .byte_i     (rx_data),
    .q_o        (rx_q)
  );

  // Value the deserializer will hold after this edge; lets the result registers
  // be valid in the same cycle res_valid is raised, including the final byte.
  assign rx_nxt   = rx_cap ? {rx_q[W2-BYTE_W-1:0], rx_data} : rx_q;
  assign tcnt_inc = tcnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    bcnt_d    = bcnt_q;
    tcnt_d    = tcnt_q;
    err_d     = err_q;
    tmo_d     = tmo_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    tx_load   = 1'b0;
    tx_shift  = 1'b0;
    rx_cap    = 1'b0;
    busy      = 1'b1;
    tx_valid  = 1'b0;
    res_valid = 1'b0;

    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          tx_load = 1'b1;
          err_d   = 1'b0;
          tmo_d   = 1'b0;
          bcnt_d  = '0;
          tcnt_d  = '0;
          state_d = SEND;
        end
      end

      SEND: begin
        tx_valid = 1'b1;
        tx_shift = 1'b1;
        if (bcnt_q == LAST_B) begin
          bcnt_d  = '0;
          tcnt_d  = '0;
          state_d = WAIT;
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end

      WAIT, RECV: begin
        err_d = err_q | div_err;
        if (rx_valid) begin
          rx_cap = 1'b1;
          tcnt_d = '0;
          if (state_q == RECV && bcnt_q == LAST_B) begin
            bcnt_d  = '0;
            state_d = REPORT;
          end else begin
            bcnt_d  = bcnt_q + 1'b1;
            state_d = RECV;
          end
        end else begin
          // Counter stops at the limit, so it never wraps.
          tcnt_d = tcnt_inc;
          if (tcnt_inc == TMO_LIM) begin
            tmo_d   = 1'b1;
            state_d = REPORT;
          end
        end
      end

      REPORT: begin
        res_valid = 1'b1;
        state_d   = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d == REPORT && state_q != REPORT) begin
      quo_d = rx_nxt[W2-1:OPERAND_W];
      rem_d = rx_nxt[OPERAND_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bcnt_q  <= '0;
      tcnt_q  <= '0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      tcnt_q  <= tcnt_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
    end
  end

  assign tx_data   = tx_valid ? tx_q[W2-1 -: BYTE_W] : '0;
  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign err       = err_q;
  assign timeout   = tmo_q;

endmodule
